// File: rtl/rdft_stage_sequencer.sv
// -----------------------------------------------------------------------------
// rdft_stage_sequencer
//
// Sequences an N = 2^N_LOG2 point radix-2 RDFT through N_LOG2 stages. It
// issues one butterfly per cycle to the shared complex butterfly/scale unit.
// Each issue's operand addresses are delayed by SCALE_LAT cycles, so the
// results are written back in place. A start/busy/done handshake links this
// block to the frame buffer controller.
//
// Optional feature macro: RDFT_STAGE_SCALE_EN
//   defined     : op_scale follows op_valid during the final stage
//                 (this is the final-stage gain compensation)
//   not defined : op_scale is tied low; the port remains present
//
// Parameters:
//   N_LOG2    log2 of the transform length (1..10)
//   SCALE_LAT latency of the butterfly/scale unit in cycles (1..8)
//   AW        address width
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous active-high reset; abandons any frame in flight
//   start      begin a transform (accepted only while idle)
//   stall      freeze issue for this cycle (buffer port conflict)
//   busy       high from start acceptance until done
//   done       one-cycle pulse after the last write-back
//   op_valid   addr_a/addr_b/tw_idx/op_scale are valid this cycle
//   addr_a     butterfly top operand address
//   addr_b     butterfly bottom operand address
//   tw_idx     twiddle ROM index
//   stage      stage number of the current/last issue
//   op_scale   scale-by-2 request to the datapath
//   wr_en      write-back strobe (op_valid delayed SCALE_LAT cycles)
//   wr_addr_a  addr_a delayed SCALE_LAT cycles
//   wr_addr_b  addr_b delayed SCALE_LAT cycles
// -----------------------------------------------------------------------------
module rdft_stage_sequencer #(
  parameter int N_LOG2    = 3,
  parameter int SCALE_LAT = 1,
  parameter int AW        = N_LOG2,
  localparam int TW       = (AW > 1) ? AW - 1 : 1,
  localparam int SW       = (N_LOG2 > 1) ? $clog2(N_LOG2) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          stall,
  output logic          busy,
  output logic          done,
  output logic          op_valid,
  output logic [AW-1:0] addr_a,
  output logic [AW-1:0] addr_b,
  output logic [TW-1:0] tw_idx,
  output logic [SW-1:0] stage,
  output logic          op_scale,
  output logic          wr_en,
  output logic [AW-1:0] wr_addr_a,
  output logic [AW-1:0] wr_addr_b
);

  localparam int            BW     = (N_LOG2 > 1) ? N_LOG2 - 1 : 1;
  localparam logic [BW-1:0] B_LAST = BW'((1 << (N_LOG2 - 1)) - 1);
  localparam logic [SW-1:0] S_LAST = SW'(N_LOG2 - 1);
  localparam logic [3:0]    D_LAST = 4'(SCALE_LAT - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  state_t        state_r, state_nx_s;
  logic [BW-1:0] b_r, b_nx_s;
  logic [SW-1:0] s_r, s_nx_s;
  logic [3:0]    cnt_r, cnt_nx_s;
  logic          issue_s;
  logic          last_b_s;
  logic          last_s_s;
  logic          scale_s;

  logic [31:0]   b32_s, s32_s, half32_s, pos32_s, grp32_s, a32_s, bb32_s, tw32_s;
  logic [AW-1:0] addr_a_s, addr_b_s;
  logic [TW-1:0] tw_idx_s;

  logic          wr_v_r [SCALE_LAT];
  logic [AW-1:0] wr_a_r [SCALE_LAT];
  logic [AW-1:0] wr_b_r [SCALE_LAT];

  assign last_b_s = (b_r == B_LAST);
  assign last_s_s = (s_r == S_LAST);

`ifdef RDFT_STAGE_SCALE_EN
  assign scale_s = issue_s & last_s_s;
`else
  assign scale_s = 1'b0;
`endif

  // Butterfly address and twiddle generation for the (stage, butterfly) pair.
  // The arithmetic uses 32 bits so the shifts never overflow, then narrows.
  always_comb begin
    b32_s    = 32'(b_r);
    s32_s    = 32'(s_r);
    half32_s = 32'd1 << s32_s;
    pos32_s  = b32_s & (half32_s - 32'd1);
    grp32_s  = b32_s >> s32_s;
    a32_s    = (grp32_s << (s32_s + 32'd1)) | pos32_s;
    bb32_s   = a32_s + half32_s;
    tw32_s   = pos32_s << (32'(N_LOG2 - 1) - s32_s);
  end

  assign addr_a_s = AW'(a32_s);
  assign addr_b_s = AW'(bb32_s);
  assign tw_idx_s = TW'(tw32_s);

  // FSM state and the butterfly/stage/drain counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= ST_IDLE;
      b_r     <= '0;
      s_r     <= '0;
      cnt_r   <= 4'd0;
    end else begin
      state_r <= state_nx_s;
      b_r     <= b_nx_s;
      s_r     <= s_nx_s;
      cnt_r   <= cnt_nx_s;
    end
  end

  // Next state, counter updates and the issue decision.
  always_comb begin
    state_nx_s = state_r;
    b_nx_s     = b_r;
    s_nx_s     = s_r;
    cnt_nx_s   = cnt_r;
    issue_s    = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (start) begin
          state_nx_s = ST_RUN;
          b_nx_s     = '0;
          s_nx_s     = '0;
        end else begin
          state_nx_s = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (!stall) begin
          issue_s = 1'b1;
          if (last_b_s) begin
            // The next stage follows directly, with no bubble between stages.
            b_nx_s = '0;
            if (last_s_s) begin
              state_nx_s = ST_DRAIN;
              cnt_nx_s   = 4'd0;
            end else begin
              s_nx_s = s_r + SW'(1);
            end
          end else begin
            b_nx_s = b_r + BW'(1);
          end
        end else begin
          issue_s = 1'b0;
        end
      end
      ST_DRAIN: begin
        // Wait until the write-back pipeline has emptied.
        if (cnt_r == D_LAST) begin
          state_nx_s = ST_DONE;
        end else begin
          cnt_nx_s = cnt_r + 4'd1;
        end
      end
      ST_DONE: begin
        state_nx_s = ST_IDLE;
      end
      default: begin
        state_nx_s = ST_IDLE;
      end
    endcase
  end

  // Registered issue outputs and handshake. The address outputs hold while no
  // issue is made.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy     <= 1'b0;
      done     <= 1'b0;
      op_valid <= 1'b0;
      op_scale <= 1'b0;
      addr_a   <= '0;
      addr_b   <= '0;
      tw_idx   <= '0;
      stage    <= '0;
    end else begin
      busy     <= (state_nx_s != ST_IDLE);
      done     <= (state_r == ST_DONE);
      op_valid <= issue_s;
      op_scale <= scale_s;
      if (issue_s) begin
        addr_a <= addr_a_s;
        addr_b <= addr_b_s;
        tw_idx <= tw_idx_s;
        stage  <= s_r;
      end else if ((state_r == ST_IDLE) && start) begin
        stage <= '0;
      end
    end
  end

  // Write-back delay line. It shifts every cycle, so issues made before a
  // stall still retire during the stall.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < SCALE_LAT; i++) begin
        wr_v_r[i] <= 1'b0;
        wr_a_r[i] <= '0;
        wr_b_r[i] <= '0;
      end
    end else begin
      wr_v_r[0] <= op_valid;
      wr_a_r[0] <= addr_a;
      wr_b_r[0] <= addr_b;
      for (int i = 1; i < SCALE_LAT; i++) begin
        wr_v_r[i] <= wr_v_r[i-1];
        wr_a_r[i] <= wr_a_r[i-1];
        wr_b_r[i] <= wr_b_r[i-1];
      end
    end
  end

  assign wr_en     = wr_v_r[SCALE_LAT-1];
  assign wr_addr_a = wr_a_r[SCALE_LAT-1];
  assign wr_addr_b = wr_b_r[SCALE_LAT-1];

endmodule

// File: tb/tb_rdft_stage_sequencer.sv
// -----------------------------------------------------------------------------
// tb_rdft_stage_sequencer
//
// Scoreboard bench. The stimulus pushes the expected issues, write-backs and
// done edges into queues. One monitor per instance pops these entries at the
// falling edge and compares them. Three instances are used:
//   u1 : N_LOG2=3, SCALE_LAT=1
//   u4 : N_LOG2=3, SCALE_LAT=4
//   u0 : N_LOG2=1, SCALE_LAT=1
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_rdft_stage_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, start1, start4, start0, stall1;

  logic       u1_busy, u1_done, u1_op_valid, u1_op_scale, u1_wr_en;
  logic [2:0] u1_addr_a, u1_addr_b, u1_wr_addr_a, u1_wr_addr_b;
  logic [1:0] u1_tw, u1_stage;

  logic       u4_busy, u4_done, u4_op_valid, u4_op_scale, u4_wr_en;
  logic [2:0] u4_addr_a, u4_addr_b, u4_wr_addr_a, u4_wr_addr_b;
  logic [1:0] u4_tw, u4_stage;

  logic       u0_busy, u0_done, u0_op_valid, u0_op_scale, u0_wr_en;
  logic [0:0] u0_addr_a, u0_addr_b, u0_wr_addr_a, u0_wr_addr_b;
  logic [0:0] u0_tw, u0_stage;

  rdft_stage_sequencer #(.N_LOG2(3), .SCALE_LAT(1)) u1 (
    .clk(clk), .rst(rst), .start(start1), .stall(stall1),
    .busy(u1_busy), .done(u1_done), .op_valid(u1_op_valid),
    .addr_a(u1_addr_a), .addr_b(u1_addr_b), .tw_idx(u1_tw), .stage(u1_stage),
    .op_scale(u1_op_scale), .wr_en(u1_wr_en),
    .wr_addr_a(u1_wr_addr_a), .wr_addr_b(u1_wr_addr_b));

  rdft_stage_sequencer #(.N_LOG2(3), .SCALE_LAT(4)) u4 (
    .clk(clk), .rst(rst), .start(start4), .stall(1'b0),
    .busy(u4_busy), .done(u4_done), .op_valid(u4_op_valid),
    .addr_a(u4_addr_a), .addr_b(u4_addr_b), .tw_idx(u4_tw), .stage(u4_stage),
    .op_scale(u4_op_scale), .wr_en(u4_wr_en),
    .wr_addr_a(u4_wr_addr_a), .wr_addr_b(u4_wr_addr_b));

  rdft_stage_sequencer #(.N_LOG2(1), .SCALE_LAT(1)) u0 (
    .clk(clk), .rst(rst), .start(start0), .stall(1'b0),
    .busy(u0_busy), .done(u0_done), .op_valid(u0_op_valid),
    .addr_a(u0_addr_a), .addr_b(u0_addr_b), .tw_idx(u0_tw), .stage(u0_stage),
    .op_scale(u0_op_scale), .wr_en(u0_wr_en),
    .wr_addr_a(u0_wr_addr_a), .wr_addr_b(u0_wr_addr_b));

`ifdef RDFT_STAGE_SCALE_EN
  localparam bit SCALE_ON = 1'b1;
`else
  localparam bit SCALE_ON = 1'b0;
`endif

  typedef struct packed {
    logic [2:0] a;
    logic [2:0] b;
    logic [1:0] tw;
    logic [1:0] st;
    logic       sc;
  } iss_t;

  typedef struct packed {
    logic [2:0] a;
    logic [2:0] b;
  } wr_t;

  // Hand-computed issue order for the 8-point transform
  int ta [12] = '{0, 2, 4, 6, 0, 1, 4, 5, 0, 1, 2, 3};
  int tb [12] = '{1, 3, 5, 7, 2, 3, 6, 7, 4, 5, 6, 7};
  int tt [12] = '{0, 0, 0, 0, 0, 2, 0, 2, 0, 1, 2, 3};

  iss_t q1[$], q4[$], q0[$];
  wr_t  w1[$], w4[$], w0[$];
  int   d1[$], d4[$], d0[$];

  int   n_vec = 0;
  int   n_err = 0;
  int   edge_cnt = 0;
  int   k;
  iss_t m1e, m4e, m0e, ent;
  wr_t  m1w, m4w, m0w, went;

  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  task automatic chk(input string nm, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at edge %0d", nm, act, exp, edge_cnt);
    end
  endtask

  task automatic wait_edge(input int e);
    while (edge_cnt < e) @(negedge clk);
  endtask

  task automatic push_n8(input int which);
    for (int i = 0; i < 12; i++) begin
      ent.a  = 3'(ta[i]);
      ent.b  = 3'(tb[i]);
      ent.tw = 2'(tt[i]);
      ent.st = 2'(i / 4);
      ent.sc = SCALE_ON && (i >= 8);
      went.a = ent.a;
      went.b = ent.b;
      if (which == 1) begin
        q1.push_back(ent);
        w1.push_back(went);
      end else begin
        q4.push_back(ent);
        w4.push_back(went);
      end
    end
  endtask

  task automatic chk_zero_u1(input string nm);
    chk(nm, int'({u1_busy, u1_done, u1_op_valid, u1_op_scale, u1_wr_en, u1_addr_a,
                  u1_addr_b, u1_tw, u1_stage, u1_wr_addr_a, u1_wr_addr_b}), 0);
  endtask

  // Monitor for u1
  always @(negedge clk) begin
    if (!rst) begin
      if (u1_op_valid) begin
        chk("u1 issue expected", int'(q1.size() != 0), 1);
        if (q1.size() != 0) begin
          m1e = q1.pop_front();
          chk("u1 issue", int'({u1_addr_a, u1_addr_b, u1_tw, u1_stage, u1_op_scale}), int'(m1e));
        end
      end
      if (u1_wr_en) begin
        chk("u1 wr expected", int'(w1.size() != 0), 1);
        if (w1.size() != 0) begin
          m1w = w1.pop_front();
          chk("u1 wr addr", int'({u1_wr_addr_a, u1_wr_addr_b}), int'(m1w));
        end
      end
      if (u1_done) begin
        chk("u1 done expected", int'(d1.size() != 0), 1);
        if (d1.size() != 0) chk("u1 done edge", edge_cnt, d1.pop_front());
        chk("u1 busy at done", int'(u1_busy), 0);
      end
    end
  end

  // Monitor for u4
  always @(negedge clk) begin
    if (!rst) begin
      if (u4_op_valid) begin
        chk("u4 issue expected", int'(q4.size() != 0), 1);
        if (q4.size() != 0) begin
          m4e = q4.pop_front();
          chk("u4 issue", int'({u4_addr_a, u4_addr_b, u4_tw, u4_stage, u4_op_scale}), int'(m4e));
        end
      end
      if (u4_wr_en) begin
        chk("u4 wr expected", int'(w4.size() != 0), 1);
        if (w4.size() != 0) begin
          m4w = w4.pop_front();
          chk("u4 wr addr", int'({u4_wr_addr_a, u4_wr_addr_b}), int'(m4w));
        end
      end
      if (u4_done) begin
        chk("u4 done expected", int'(d4.size() != 0), 1);
        if (d4.size() != 0) chk("u4 done edge", edge_cnt, d4.pop_front());
      end
    end
  end

  // Monitor for u0
  always @(negedge clk) begin
    if (!rst) begin
      if (u0_op_valid) begin
        chk("u0 issue expected", int'(q0.size() != 0), 1);
        if (q0.size() != 0) begin
          m0e = q0.pop_front();
          chk("u0 issue", int'({u0_addr_a, u0_addr_b, u0_tw, u0_stage, u0_op_scale}),
              int'({m0e.a[0], m0e.b[0], m0e.tw[0], m0e.st[0], m0e.sc}));
        end
      end
      if (u0_wr_en) begin
        chk("u0 wr expected", int'(w0.size() != 0), 1);
        if (w0.size() != 0) begin
          m0w = w0.pop_front();
          chk("u0 wr addr", int'({u0_wr_addr_a, u0_wr_addr_b}), int'({m0w.a[0], m0w.b[0]}));
        end
      end
      if (u0_done) begin
        chk("u0 done expected", int'(d0.size() != 0), 1);
        if (d0.size() != 0) chk("u0 done edge", edge_cnt, d0.pop_front());
      end
    end
  end

  initial begin
    rst    = 1'b1;
    start1 = 1'b0;
    start4 = 1'b0;
    start0 = 1'b0;
    stall1 = 1'b0;
    repeat (2) @(negedge clk);
    chk_zero_u1("u1 reset state");
    chk("u4 reset state", int'({u4_busy, u4_done, u4_op_valid, u4_op_scale, u4_wr_en}), 0);
    chk("u0 reset state", int'({u0_busy, u0_done, u0_op_valid, u0_op_scale, u0_wr_en}), 0);
    rst = 1'b0;
    @(negedge clk);

    // Plain transform: check the timing of busy, op_valid and wr_en
    k = edge_cnt + 1;
    start1 = 1'b1;
    push_n8(1);
    d1.push_back(k + 14);
    @(negedge clk);
    start1 = 1'b0;
    chk("t1 busy after start", int'(u1_busy), 1);
    chk("t1 op_valid at start edge", int'(u1_op_valid), 0);
    wait_edge(k + 1);
    chk("t1 first op_valid", int'({u1_op_valid, u1_wr_en}), 2);
    wait_edge(k + 2);
    chk("t1 first wr_en", int'(u1_wr_en), 1);
    wait_edge(k + 13);
    chk("t1 last wr only", int'({u1_op_valid, u1_wr_en, u1_done}), 2);
    wait_edge(k + 14);
    chk("t1 wr_en off at done", int'(u1_wr_en), 0);
    wait_edge(k + 16);

    // Stall for 3 cycles after the 5th issue
    k = edge_cnt + 1;
    start1 = 1'b1;
    push_n8(1);
    d1.push_back(k + 17);
    @(negedge clk);
    start1 = 1'b0;
    wait_edge(k + 5);
    stall1 = 1'b1;
    for (int j = 6; j <= 8; j++) begin
      wait_edge(k + j);
      chk("t2 op_valid in stall", int'(u1_op_valid), 0);
      chk("t2 addr hold in stall", int'({u1_addr_a, u1_addr_b}), 2);
      if (j == 6) chk("t2 wr retires in stall", int'(u1_wr_en), 1);
    end
    stall1 = 1'b0;
    wait_edge(k + 9);
    chk("t2 issue resumes", int'(u1_op_valid), 1);
    wait_edge(k + 19);

    // Reset in the middle of stage 1, then replay from the start
    k = edge_cnt + 1;
    start1 = 1'b1;
    push_n8(1);
    d1.push_back(k + 14);
    @(negedge clk);
    start1 = 1'b0;
    wait_edge(k + 6);
    #2 rst = 1'b1;
    #1 chk_zero_u1("t3 outputs under reset");
    q1.delete();
    w1.delete();
    d1.delete();
    @(negedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    k = edge_cnt + 1;
    start1 = 1'b1;
    push_n8(1);
    d1.push_back(k + 14);
    @(negedge clk);
    start1 = 1'b0;
    wait_edge(k + 16);

    // Start held high: the second transform is accepted the cycle after done
    k = edge_cnt + 1;
    start1 = 1'b1;
    push_n8(1);
    push_n8(1);
    d1.push_back(k + 14);
    d1.push_back(k + 29);
    wait_edge(k + 15);
    start1 = 1'b0;
    chk("t4 busy again after done", int'({u1_busy, u1_op_valid}), 2);
    wait_edge(k + 16);
    chk("t4 second transform issues", int'(u1_op_valid), 1);
    wait_edge(k + 31);

    // SCALE_LAT=4 instance
    k = edge_cnt + 1;
    start4 = 1'b1;
    push_n8(4);
    d4.push_back(k + 17);
    @(negedge clk);
    start4 = 1'b0;
    wait_edge(k + 4);
    chk("t5 wr_en before latency", int'(u4_wr_en), 0);
    wait_edge(k + 5);
    chk("t5 wr_en after latency", int'(u4_wr_en), 1);
    wait_edge(k + 19);

    // N_LOG2=1 instance: a single butterfly
    k = edge_cnt + 1;
    start0 = 1'b1;
    ent.a  = 3'd0;
    ent.b  = 3'd1;
    ent.tw = 2'd0;
    ent.st = 2'd0;
    ent.sc = SCALE_ON;
    went.a = 3'd0;
    went.b = 3'd1;
    q0.push_back(ent);
    w0.push_back(went);
    d0.push_back(k + 3);
    @(negedge clk);
    start0 = 1'b0;
    wait_edge(k + 5);

    chk("u1 queues drained", q1.size() + w1.size() + d1.size(), 0);
    chk("u4 queues drained", q4.size() + w4.size() + d4.size(), 0);
    chk("u0 queues drained", q0.size() + w0.size() + d0.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/rdft_stage_sequencer.md
Name: rdft_stage_sequencer

Overview:
- Controls the radix-2 RDFT datapath. Walks an N=2^N_LOG2 point transform through N_LOG2 stages and issues one butterfly per cycle.
- For each issue it drives the operand address pair, twiddle index and scale control to the shared 32-bit complex butterfly/scale unit (real + j paths).
- Each issue's write-back addresses are delayed by the unit latency so results land in place. A start/busy/done handshake links it to the frame buffer controller.

Parameters:
- N_LOG2, 3, log2 of transform length; legal range 1..10.
- SCALE_LAT, 1, pipeline latency of the butterfly/scale unit in cycles; legal range 1..8.
- AW, N_LOG2, address width.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  reset, asynchronous, active-high
- start  in  1  pulse; begin transform; accepted only in IDLE
- stall  in  1  freezes issue while high (buffer port conflict)
- busy  out  1  high from start acceptance until done
- done  out  1  one-cycle pulse after the last write-back
- op_valid  out  1  addr_a/addr_b/tw_idx/op_scale valid this cycle
- addr_a  out  AW  butterfly top operand address
- addr_b  out  AW  butterfly bottom operand address
- tw_idx  out  AW-1 (min 1)  twiddle ROM index
- stage  out  max(1,clog2(N_LOG2))  current stage number
- op_scale  out  1  scale-by-2 (<<<1 on real and j) request to the datapath
- wr_en  out  1  write-back strobe, op_valid delayed SCALE_LAT cycles
- wr_addr_a  out  AW  addr_a delayed SCALE_LAT cycles
- wr_addr_b  out  AW  addr_b delayed SCALE_LAT cycles

Behaviour:
- Reset (async, any time including mid-transform): state IDLE. Every output is 0: busy, done, op_valid, wr_en, addresses, tw_idx, stage, op_scale. Delay line cleared. The in-flight frame is abandoned.
- States:
  - IDLE: start=1 -> RUN, busy=1, stage=0, b=0.
  - RUN: one issue per cycle while stall=0. After issuing b=N/2-1 of the last stage -> DRAIN.
  - DRAIN: count SCALE_LAT cycles for the write-back pipeline to empty -> DONE.
  - DONE: done=1 for one cycle, busy=0 -> IDLE.
- Issue math, stage s, butterfly b in 0..N/2-1:
  - half = 1<<s; pos = b & (half-1); grp = b>>s
  - addr_a = grp*2*half + pos; addr_b = addr_a + half
  - tw_idx = pos << (N_LOG2-1-s)
- b increments per issue and wraps to 0 at N/2-1; stage then increments. There is no idle bubble between stages.
- stall=1 in RUN: op_valid=0 that cycle, and counters and address outputs hold. The wr delay line keeps shifting, so earlier issues still retire.
- While op_valid=0, address outputs hold their last values. Consumers must gate on op_valid/wr_en.
- start is ignored while busy, and ignored in the DONE cycle. A start in the cycle immediately after done is accepted.
- Timing with stall=0, start at edge k:
  - op_valid high cycles k+1 .. k+N_LOG2*N/2
  - wr_en lags op_valid by SCALE_LAT cycles
  - done occurs the cycle after the last wr_en
- Widths are unsigned. Address arithmetic wraps modulo 2^AW, which cannot occur for legal parameters.

Optional Feature:
- Macro: RDFT_STAGE_SCALE_EN.
- Defined: op_scale = op_valid during stage N_LOG2-1 only. This commands the datapath doubling unit (<<<1 on real and j) as final-stage gain compensation.
- Not defined: op_scale is tied to 0; the port remains present.

Test Plan:
- N_LOG2=3, SCALE_LAT=1, start pulse, stall=0 -> (addr_a,addr_b,tw_idx) sequence:
  - stage 0: (0,1,0) (2,3,0) (4,5,0) (6,7,0)
  - stage 1: (0,2,0) (1,3,2) (4,6,0) (5,7,2)
  - stage 2: (0,4,0) (1,5,1) (2,6,2) (3,7,3)
  - op_valid for 12 cycles, wr_en for 12 cycles one cycle later, done pulse 14 cycles after the start edge, busy low after.
- Same config, stall=1 for 3 cycles after the 5th issue -> op_valid gap of 3; addr_a/addr_b hold (0,2); done shifts to 17 cycles; wr_en sequence unchanged, only delayed.
- Assert rst mid-stage 1 -> all outputs 0 immediately. A new start then replays from stage 0, b=0.
- start held high through a full transform -> the second transform begins the cycle after done; no issue is accepted while busy.
- SCALE_LAT=4, RDFT_STAGE_SCALE_EN defined -> op_scale=1 exactly on the last 4 issues; wr_addr_a/wr_addr_b equal addr_a/addr_b delayed 4 cycles; done 17 cycles after start.
- N_LOG2=1 -> single issue (0,1,0); done 3 cycles after start with SCALE_LAT=1.
